z80_int_ctrl: RTL

Vectored interrupt controller on the z80 system bus, peer to `memory`. It sits directly upstream of the `z80` core's `INT_L` input. It latches up to eight external request lines, selects the highest-priority enabled request, and asserts `INT_L`. During the mode-2 interrupt-acknowledge cycle it drives the vector byte onto `data_bus`. Mask, vector base and end-of-interrupt are programmed through three I/O ports.

---
 rtl/z80_intc_pkg.sv | 32 +++
 rtl/z80_int_ctrl_irq_sync_edge.sv | 30 +++
 rtl/z80_int_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/z80_intc_pkg.sv
// Shared types and helpers for the z80 vectored interrupt controller.
package z80_intc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    ACK     = 2'd2
  } intc_state_t;

  localparam logic [7:0] MASK_OFS = 8'd0;
  localparam logic [7:0] VEC_OFS  = 8'd1;
  localparam logic [7:0] EOI_OFS  = 8'd2;

  // Mode-2 vector: upper nibble from vbase, line index in [3:1], always even.
  function automatic logic [7:0] make_vec(input logic [7:0] vbase, input logic [2:0] idx);
    logic [7:0] v;
    v      = vbase;
    v[3:0] = {idx, 1'b0};
    return v;
  endfunction

  // Returns {valid, idx} for the lowest set bit of req.
  function automatic logic [3:0] prio_enc(input logic [7:0] req);
    logic [3:0] res;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/z80_int_ctrl_irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous request line, followed by a
// one-cycle pulse on each synchronized rising edge.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_L,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/z80_int_ctrl.sv
// Eight-line vectored (mode-2) interrupt controller for the z80 bus.
// Optional RETI (ED 4D) opcode snooping is enabled by defining INT_RETI_DETECT_EN.
module z80_int_ctrl
  import z80_intc_pkg::*;
#(
  parameter logic [7:0] BASE_PORT = 8'h80
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic [7:0]  irq,
  input  logic [15:0] addr_bus,
  inout  wire  [7:0]  data_bus,
  input  logic        M1_L,
  input  logic        MREQ_L,
  input  logic        IORQ_L,
  input  logic        RD_L,
  input  logic        WR_L,
  output logic        INT_L
);

  localparam logic [7:0] L_MASK_PORT = BASE_PORT + MASK_OFS;
  localparam logic [7:0] L_VEC_PORT  = BASE_PORT + VEC_OFS;
  localparam logic [7:0] L_EOI_PORT  = BASE_PORT + EOI_OFS;

  intc_state_t r_state;
  intc_state_t w_state_nxt;

  logic [7:0] r_mask;
  logic [7:0] r_vbase;
  logic [7:0] r_pend;
  logic [7:0] r_insvc;
  logic [7:0] r_vec;
  logic [2:0] r_idx;
  logic       r_int_l;
  logic       r_io_wr_q;

  logic [7:0] w_set;
  logic [7:0] w_insvc_nxt;
  logic [7:0] w_ack_onehot;
  logic [7:0] w_le_mask;
  logic [7:0] w_dout;
  logic [7:0] w_addr;
  logic [3:0] w_pe;
  logic [2:0] w_win_idx;
  logic       w_win_valid;
  logic       w_eligible;
  logic       w_ack_take;
  logic       w_ack_bus;
  logic       w_io_wr;
  logic       w_io_rd;
  logic       w_wr_stb;
  logic       w_wr_mask;
  logic       w_wr_vbase;
  logic       w_wr_eoi;
  logic       w_drive;
  logic       w_unused;

  for (genvar g = 0; g < 8; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk     (clk),
      .rst_L   (rst_L),
      .i_async (irq[g]),
      .o_pulse (w_set[g])
    );
  end

  assign w_addr    = addr_bus[7:0];
  assign w_ack_bus = ~M1_L & ~IORQ_L;
  assign w_io_wr   = ~IORQ_L & ~WR_L & M1_L;
  assign w_io_rd   = ~IORQ_L & ~RD_L & M1_L;
  assign w_wr_stb  = w_io_wr & ~r_io_wr_q;

  assign w_wr_mask  = w_wr_stb && (w_addr == L_MASK_PORT);
  assign w_wr_vbase = w_wr_stb && (w_addr == L_VEC_PORT);
  assign w_wr_eoi   = w_wr_stb && (w_addr == L_EOI_PORT);

  // A winner is eligible only if no line at or above its priority is in service.
  assign w_pe        = prio_enc(r_pend & r_mask);
  assign w_win_valid = w_pe[3];
  assign w_win_idx   = w_pe[2:0];
  assign w_le_mask   = ~(8'hFE << w_win_idx);
  assign w_eligible  = w_win_valid && ((r_insvc & w_le_mask) == 8'h00);

  assign w_ack_onehot = w_ack_take ? (8'h01 << r_idx) : 8'h00;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_take  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_eligible) w_state_nxt = REQUEST;
      end
      REQUEST: begin
        if (w_ack_bus) begin
          w_state_nxt = ACK;
          w_ack_take  = 1'b1;
        end else if (!w_eligible) begin
          w_state_nxt = IDLE;
        end
      end
      ACK: begin
        if (IORQ_L) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef INT_RETI_DETECT_EN
  logic       r_fetch_q;
  logic       r_ed_seen;
  logic [7:0] r_opcode;
  logic       w_fetch;
  logic       w_fetch_end;
  logic       w_reti;

  // Opcode byte is taken on the last edge of the fetch and judged once it ends.
  assign w_fetch     = ~M1_L & ~MREQ_L & ~RD_L;
  assign w_fetch_end = r_fetch_q & ~w_fetch;
  assign w_reti      = w_fetch_end & r_ed_seen & (r_opcode == 8'h4D);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_fetch_q <= 1'b0;
      r_ed_seen <= 1'b0;
      r_opcode  <= 8'h00;
    end else begin
      r_fetch_q <= w_fetch;
      if (w_fetch) r_opcode <= data_bus;
      if (w_fetch_end) r_ed_seen <= r_ed_seen ? 1'b0 : (r_opcode == 8'hED);
    end
  end
`endif

  always_comb begin
    w_insvc_nxt = r_insvc | w_ack_onehot;
    if (w_wr_eoi) w_insvc_nxt = w_insvc_nxt & ~data_bus;
`ifdef INT_RETI_DETECT_EN
    if (w_reti) w_insvc_nxt = w_insvc_nxt & ~(r_insvc & (~r_insvc + 8'd1));
`endif
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state   <= IDLE;
      r_int_l   <= 1'b1;
      r_mask    <= 8'h00;
      r_vbase   <= 8'h00;
      r_pend    <= 8'h00;
      r_insvc   <= 8'h00;
      r_vec     <= 8'h00;
      r_idx     <= 3'd0;
      r_io_wr_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_int_l   <= (w_state_nxt != REQUEST);
      r_io_wr_q <= w_io_wr;
      // A fresh edge on a line being acknowledged keeps it pending.
      r_pend    <= (r_pend & ~w_ack_onehot) | w_set;
      r_insvc   <= w_insvc_nxt;
      if (w_wr_mask)  r_mask  <= data_bus;
      if (w_wr_vbase) r_vbase <= data_bus;
      if (w_state_nxt == REQUEST) begin
        r_vec <= make_vec(r_vbase, w_win_idx);
        r_idx <= w_win_idx;
      end
    end
  end

  always_comb begin
    w_drive = 1'b0;
    w_dout  = r_vec;
    if (w_ack_bus && (r_state == REQUEST || r_state == ACK)) begin
      w_drive = 1'b1;
    end else if (w_io_rd) begin
      if (w_addr == L_MASK_PORT) begin
        w_drive = 1'b1;
        w_dout  = r_mask;
      end else if (w_addr == L_VEC_PORT) begin
        w_drive = 1'b1;
        w_dout  = r_pend;
      end else if (w_addr == L_EOI_PORT) begin
        w_drive = 1'b1;
        w_dout  = r_insvc;
      end
    end
  end

  assign data_bus = w_drive ? w_dout : 8'hzz;
  assign INT_L    = r_int_l;
  assign w_unused = ^{addr_bus[15:8], MREQ_L};

endmodule
